ysyx_22050039_lsu: RTL
======================

Name: ysyx_22050039_lsu

Overview:
- Multi-cycle load/store unit for the ysyx_22050039 RISC-V core, replacing the single-cycle combinational pmem access inside EXU.
- Accepts one load/store request from EXU and drives a valid/ready memory port that tolerates variable latency.
- Returns sign/zero-extended load data or a store acknowledge.
- Parametrised in data width and address width; handles misalignment and memory timeout by reporting an error.

Parameters:
XLEN, 64, data width in bits; 32 or 64 only
ADDR_W, 64, address width in bits
TIMEOUT, 255, max cycles in WAIT before error; 0 disables timeout

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  EXU request valid
req_ready  out  1  LSU can accept request
req_op  in  4  [3]=store, [2]=unsigned load, [1:0]=size (0 B, 1 H, 2 W, 3 D)
req_addr  in  ADDR_W  byte address, already computed as base+offset
req_wdata  in  XLEN  store data, right-aligned
rsp_valid  out  1  response valid
rsp_ready  in  1  EXU accepts response
rsp_rdata  out  XLEN  extended load data; 0 for stores
rsp_err  out  1  misaligned, illegal size, or timeout
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  req_addr with low log2(XLEN/8) bits cleared
mem_wdata  out  XLEN  store data shifted into byte lane
mem_wmask  out  XLEN/8  byte enables
mem_rsp_valid  in  1  read data / write ack valid
mem_rdata  in  XLEN  aligned read word

Behaviour:
- Reset (synchronous, active-high, priority over everything):
  - state=IDLE; req_ready=1.
  - rsp_valid, rsp_err, mem_req_valid, mem_we = 0; rsp_rdata, mem_wmask = 0; timeout counter = 0.
  - rst in any state aborts the operation; nothing is replayed.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op/addr/wdata.
  - If misaligned (addr mod size bytes != 0) or size=3 with XLEN=32 → RESP with err=1; no memory access.
  - Otherwise → REQ.
- REQ:
  - mem_req_valid=1 with stable addr/we/wdata/wmask until mem_req_ready.
  - Handshake cycle → WAIT; counter cleared.
- WAIT:
  - mem_rsp_valid → capture data, → RESP, err=0.
  - Counter increments each cycle. If TIMEOUT!=0 and counter reaches TIMEOUT → RESP, err=1, rdata=0.
  - mem_rsp_valid arriving in the same cycle as the timeout wins (err=0).
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_ready.
  - On rsp_ready → IDLE.
  - req_ready=0 in all states except IDLE, so throughput is one op per at least 4 cycles.
- Minimum latency (mem_req_ready=1, mem_rsp_valid next cycle):
  - accept at cycle 0, mem request at cycle 1, data at cycle 2, rsp_valid at cycle 3.
- Store lane rules:
  - off = addr[log2(XLEN/8)-1:0].
  - mem_wmask = ((1<<(1<<size))-1) << off.
  - mem_wdata = req_wdata << (8*off); bytes outside the mask are don't-care, driven as the shifted value.
- Load extraction:
  - Shift mem_rdata right by 8*off, truncate to the access size.
  - Sign-extend unless op[2]=1. Ld ignores op[2].
- Stores: rsp_rdata=0. A store completes only on mem_rsp_valid (write ack).
- Stray mem_rsp_valid outside WAIT is ignored.
- A simulation assertion fires if mem_req_ready is seen while mem_req_valid=0.

Test Plan:
1. Lb (op 4'b0000) at 0x8000_0003, mem_rdata=0x1122_3344_8566_7788 → mem_addr=0x8000_0000, rsp_rdata=0xFFFF_FFFF_FFFF_FF85, err=0.
2. Lhu (op 4'b0101) at 0x8000_0006, same mem_rdata → rsp_rdata=0x0000_0000_0000_1122.
3. Sw (op 4'b1010) at 0x8000_0004, wdata=0xDEAD_BEEF → mem_wmask=0xF0, mem_wdata[63:32]=0xDEAD_BEEF, mem_we=1; rsp_valid after ack, rdata=0.
4. Lw (op 4'b0010) at 0x8000_0002 → rsp_valid at cycle 1, err=1; mem_req_valid never asserted.
5. Ld with mem_rsp_valid withheld, TIMEOUT=8 → rsp_err=1 after 8 WAIT cycles. Repeat with mem_req_ready low 5 cycles, then the response: latency grows by 5, err=0.
6. rst asserted during WAIT → next cycle IDLE, req_ready=1, rsp_valid=0; a later stray mem_rsp_valid produces no response. Also rsp_ready held low 3 cycles → rsp_rdata stable, req_ready=0 throughout.

Source files
------------

// File: rtl/ysyx_22050039_lsu.sv
// Multi-cycle load/store unit: takes one EXU request, performs a single aligned
// memory transaction over a variable-latency port, and returns extended load data.
module ysyx_22050039_lsu #(
  parameter int XLEN    = 64,
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [XLEN-1:0]     rsp_rdata,
  output logic                rsp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [XLEN-1:0]     mem_rdata
);
  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  // Handshakes: a transfer happens on the rising edge where valid and ready are
  // both high; once raised, valid and its payload stay stable until that edge.
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t            state;
  logic [3:0]        op_q;
  logic [OFF_W-1:0]  off_q;
  logic [31:0]       wait_cnt;

  logic [1:0]        size;
  logic              misaligned;
  logic              illegal;
  logic [7:0]        size_mask;
  logic [STRB_W-1:0] wmask_n;
  logic [XLEN-1:0]   wdata_n;
  logic [XLEN-1:0]   sh;
  logic [63:0]       sh64;
  logic [63:0]       ext;
  logic [XLEN-1:0]   load_data;

  always_comb begin
    size       = req_op[1:0];
    misaligned = 1'b0;
    size_mask  = 8'h01;
    case (size)
      2'd0: begin misaligned = 1'b0;             size_mask = 8'h01; end
      2'd1: begin misaligned = req_addr[0];      size_mask = 8'h03; end
      2'd2: begin misaligned = |req_addr[1:0];   size_mask = 8'h0F; end
      default: begin misaligned = |req_addr[2:0]; size_mask = 8'hFF; end
    endcase
    illegal = (size == 2'd3) && (XLEN == 32);
    wmask_n = STRB_W'({8'h00, size_mask} << req_addr[OFF_W-1:0]);
    wdata_n = req_wdata << {req_addr[OFF_W-1:0], 3'b000};
  end

  // Load extraction is done in a 64-bit scratch so the same code serves XLEN=32.
  always_comb begin
    sh   = mem_rdata >> {off_q, 3'b000};
    sh64 = 64'(sh);
    case (op_q[1:0])
      2'd0:    ext = {{56{~op_q[2] & sh64[7]}},  sh64[7:0]};
      2'd1:    ext = {{48{~op_q[2] & sh64[15]}}, sh64[15:0]};
      2'd2:    ext = {{32{~op_q[2] & sh64[31]}}, sh64[31:0]};
      default: ext = sh64;
    endcase
    load_data = ext[XLEN-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_err       <= 1'b0;
      rsp_rdata     <= '0;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wmask     <= '0;
      op_q          <= '0;
      off_q         <= '0;
      wait_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            off_q     <= req_addr[OFF_W-1:0];
            req_ready <= 1'b0;
            if (misaligned || illegal) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state         <= REQ;
              mem_req_valid <= 1'b1;
              mem_we        <= req_op[3];
              mem_addr      <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              mem_wdata     <= req_op[3] ? wdata_n : '0;
              mem_wmask     <= req_op[3] ? wmask_n : '0;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            state         <= WAIT;
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_wmask     <= '0;
            wait_cnt      <= '0;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 32'd1;
          // A response landing on the timeout cycle still counts as success.
          if (mem_rsp_valid) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= op_q[3] ? '0 : load_data;
          end else if ((TIMEOUT != 0) && (wait_cnt + 32'd1 == 32'(TIMEOUT))) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end
        end
        default: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            req_ready <= 1'b1;
          end
        end
      endcase
    end
  end

  mem_ready_without_valid: assert property (
    @(posedge clk) disable iff (rst) mem_req_ready |-> mem_req_valid);

endmodule
